// File: rtl/fetch_align.sv
// Instruction-fetch alignment: buffers 32-bit fetch words as halfwords and
// hands out whole 16/32-bit instructions (including word-straddling ones) with their PC.
module fetch_align #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          BUF_HW   = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_is_c,
   output logic [31:0] out_pc
);

   logic [15:0] fifo [0:3];
   logic [1:0]  head;
   logic [2:0]  count;
   logic [31:0] pc;
   logic        drop_lo;

   logic [15:0] hw0;
   logic [15:0] hw1;
   logic        head_c;
   logic        push;
   logic        pop;
   logic [2:0]  push_cnt;
   logic [2:0]  pop_cnt;
   logic [1:0]  tail;
   logic [1:0]  tail_p1;

   assign hw0     = fifo[head];
   assign hw1     = fifo[head + 2'd1];
   assign head_c  = (hw0[1:0] != 2'b11);
   assign tail    = head + count[1:0];
   assign tail_p1 = tail + 2'd1;

   // A 32-bit instruction needs both halves present before it is offered.
   assign out_valid = ((count >= 3'd1) && head_c) || (count >= 3'd2);
   assign in_ready  = (count <= 3'(BUF_HW - 2));
   assign out_is_c  = out_valid && head_c;
   assign out_pc    = pc;

   always_comb begin
      out_inst = 32'h0;
      if (out_valid) begin
         if (head_c) out_inst = {16'h0, hw0};
         else        out_inst = {hw1, hw0};
      end
   end

   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign push_cnt = push ? (drop_lo ? 3'd1 : 3'd2) : 3'd0;
   assign pop_cnt  = pop ? (head_c ? 3'd1 : 3'd2) : 3'd0;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         count   <= 3'd0;
         head    <= 2'd0;
         pc      <= RESET_PC & ~32'h1;
         drop_lo <= RESET_PC[1];
      end else if (flush) begin
         count   <= 3'd0;
         head    <= 2'd0;
         pc      <= flush_pc & ~32'h1;
         drop_lo <= flush_pc[1];
      end else begin
         count <= count + push_cnt - pop_cnt;
         head  <= head + pop_cnt[1:0];
         pc    <= pc + {28'd0, pop_cnt, 1'b0};
         if (push) drop_lo <= 1'b0;
      end
   end

   // Writes land beyond the live entries, so they never disturb the halfwords being popped.
   always_ff @(posedge clk) begin
      if (nrst && !flush && push) begin
         if (drop_lo) begin
            fifo[tail] <= in_data[31:16];
         end else begin
            fifo[tail]    <= in_data[15:0];
            fifo[tail_p1] <= in_data[31:16];
         end
      end
   end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: stimulus queues expected instructions, a
// negedge monitor compares every accepted output against the queue.
module tb_fetch_align;

   logic        clk = 1'b0;
   logic        nrst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        flush;
   logic [31:0] flush_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_is_c;
   logic [31:0] out_pc;

   typedef struct packed {
      logic [31:0] inst;
      logic        is_c;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   fetch_align #(.RESET_PC(32'h0000_0000), .BUF_HW(4)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .flush_pc  (flush_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_is_c  (out_is_c),
      .out_pc    (out_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_inst(input logic [31:0] inst, input logic is_c, input logic [31:0] pc);
      exp_q.push_back('{inst: inst, is_c: is_c, pc: pc});
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      flush = 1'b0;
      step();
      nrst = 1'b1;
   endtask

   task automatic push_word(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
   endtask

   // Monitor: an accepted output is one the DUT will pop at the coming edge.
   always @(negedge clk) begin
      if (nrst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", out_inst, 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_inst", out_inst, e.inst);
            chk("sb_is_c", {31'd0, out_is_c}, {31'd0, e.is_c});
            chk("sb_pc", out_pc, e.pc);
         end
      end
   end

   initial begin
      nrst = 1'b0; in_valid = 1'b0; in_data = 32'h0; flush = 1'b0;
      flush_pc = 32'h0; out_ready = 1'b0;
      step();
      do_reset();

      // 1: reset state, then a single 32-bit instruction
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_inst", out_inst, 32'h0);
      chk("rst_out_is_c", {31'd0, out_is_c}, 32'd0);
      chk("rst_out_pc", out_pc, 32'h0);
      expect_inst(32'h00A00513, 1'b0, 32'h0);
      push_word(32'h00A00513);
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t1_empty", {31'd0, out_valid}, 32'd0);

      // 2: two compressed halves of one word
      do_reset();
      out_ready = 1'b1;
      expect_inst(32'h00000001, 1'b1, 32'h0);
      expect_inst(32'h00004505, 1'b1, 32'h2);
      push_word(32'h45050001);
      step();
      step();
      chk("t2_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // 3: 32-bit instruction straddling a word boundary
      do_reset();
      out_ready = 1'b1;
      expect_inst(32'h00000001, 1'b1, 32'h0);
      push_word(32'h05130001);
      step();
      chk("t3_partial_valid", {31'd0, out_valid}, 32'd0);
      step();
      chk("t3_partial_hold", {31'd0, out_valid}, 32'd0);
      chk("t3_partial_inst", out_inst, 32'h0);
      out_ready = 1'b0;
      expect_inst(32'h00A00513, 1'b0, 32'h2);
      push_word(32'h000000A0);
      chk("t3_straddle_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // 4: backpressure fills the buffer, then drains without loss
      do_reset();
      expect_inst(32'h00A00513, 1'b0, 32'h0);
      expect_inst(32'h00B00593, 1'b0, 32'h4);
      expect_inst(32'h00C00613, 1'b0, 32'h8);
      in_valid = 1'b1;
      in_data = 32'h00A00513;
      step();
      chk("t4_ready_cnt2", {31'd0, in_ready}, 32'd1);
      in_data = 32'h00B00593;
      step();
      chk("t4_ready_full", {31'd0, in_ready}, 32'd0);
      in_data = 32'h00C00613;
      step();
      chk("t4_ready_held", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      chk("t4_drained", {31'd0, out_valid}, 32'd0);

      // 5: flush with three halfwords buffered, misaligned target
      do_reset();
      push_word(32'h45050001);
      expect_inst(32'h00000001, 1'b1, 32'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      push_word(32'h00A00513);
      flush = 1'b1;
      flush_pc = 32'h0000_0103;
      in_valid = 1'b1;
      in_data = 32'hDEADBEEF;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_flush_pc", out_pc, 32'h0000_0102);
      chk("t5_flush_ready", {31'd0, in_ready}, 32'd1);
      expect_inst(32'h00004505, 1'b1, 32'h0000_0102);
      push_word(32'h4505ABCD);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5_after_drop", {31'd0, out_valid}, 32'd0);

      // 6: reset mid-straddle, then reset beating flush
      do_reset();
      out_ready = 1'b1;
      expect_inst(32'h00000001, 1'b1, 32'h0);
      push_word(32'h05130001);
      step();
      out_ready = 1'b0;
      chk("t6_partial", {31'd0, out_valid}, 32'd0);
      do_reset();
      chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("t6_rst_pc", out_pc, 32'h0);
      expect_inst(32'h000000A0, 1'b1, 32'h0);
      push_word(32'h000000A0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      flush = 1'b1;
      flush_pc = 32'h0000_0200;
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      flush = 1'b0;
      chk("t6_rst_over_flush_pc", out_pc, 32'h0);
      chk("t6_rst_over_flush_valid", {31'd0, out_valid}, 32'd0);

      step();
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
